// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; uart_busy flags a full FIFO
// back to the memory-map decoder, tx_idle flags a fully drained transmitter.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_write,
  input  logic [7:0] uart_data,
  output logic       uart_busy,
  output logic       tx,
  output logic       tx_idle
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic push_c;
  logic pop_c;
  logic empty_c;
  logic bit_end_c;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign empty_c   = (count_q == '0);
  assign push_c    = uart_write && (count_q != CntFull);
  assign bit_end_c = (baud_q == BaudLast);

  assign uart_busy = (count_q == CntFull);
  assign tx_idle   = (state_q == IDLE) && empty_c;
  assign tx        = tx_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty_c) state_d = START;
      end
      START: begin
        if (bit_end_c) state_d = DATA;
      end
      DATA: begin
        if (bit_end_c && (bit_idx_q == 3'd7)) state_d = STOP;
      end
      STOP: begin
        if (bit_end_c) state_d = empty_c ? IDLE : START;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop request, bit timing, shifter and the next tx level
  always_comb begin
    pop_c     = 1'b0;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          // Back-to-back frames: the next byte is loaded on the last stop cycle.
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        baud_d = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Datapath and FIFO control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // FIFO storage; stale entries are harmless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= uart_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit: per-cycle vector tables
// plus hand-written sequences checked against a free-running 8N1 receiver.
module tb_uart_tx_fifo;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;
  localparam int          Frame = 10 * Cpb;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_write;
  logic [7:0] uart_data;
  logic       uart_busy;
  logic       tx;
  logic       tx_idle;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_write(uart_write),
    .uart_data (uart_data),
    .uart_busy (uart_busy),
    .tx        (tx),
    .tx_idle   (tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       exp_tx;
    logic       exp_busy;
    logic       exp_idle;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    int         start;
    logic       stop_ok;
  } rx_t;

  vec_t vecs[$];
  rx_t  rxq[$];
  logic rx_en = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // 10-bit 8N1 frame, index 0 = start bit, 1..8 = data LSB first, 9 = stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[k];
  endfunction

  // Expected per-cycle outputs for nbytes written on consecutive cycles into an idle block
  task automatic build_table(input logic [7:0] b0, input logic [7:0] b1,
                             input int nbytes, input int len);
    vec_t v;
    int   k;
    vecs.delete();
    for (int c = 0; c < len; c++) begin
      v.wr       = (c < nbytes);
      v.data     = (c == 0) ? b0 : b1;
      v.exp_busy = 1'b0;
      k          = c - 2;
      if (k >= 0 && k < Frame * nbytes)
        v.exp_tx = frame_bit(((k / Frame) == 0) ? b0 : b1, (k % Frame) / Cpb);
      else
        v.exp_tx = 1'b1;
      v.exp_idle = (c == 0) || (c >= 2 + Frame * nbytes);
      vecs.push_back(v);
    end
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      uart_write = vecs[i].wr;
      uart_data  = vecs[i].data;
      check($sformatf("%s_tx[%0d]", name, i), 32'(tx), 32'(vecs[i].exp_tx));
      check($sformatf("%s_busy[%0d]", name, i), 32'(uart_busy), 32'(vecs[i].exp_busy));
      check($sformatf("%s_idle[%0d]", name, i), 32'(tx_idle), 32'(vecs[i].exp_idle));
      tick();
    end
    uart_write = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && !tx_idle; i++) tick();
    check($sformatf("%s_drain", name), 32'(tx_idle), 32'd1);
    repeat (4) tick();
  endtask

  // Free-running receiver sampling mid-bit
  initial begin : rx_proc
    rx_t r;
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        r.start = cyc;
        r.b     = 8'h00;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (Cpb) @(negedge clk);
          r.b[k] = tx;
        end
        repeat (Cpb) @(negedge clk);
        r.stop_ok = (tx === 1'b1);
        rxq.push_back(r);
        @(negedge clk);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   n0;
    logic all_quiet;

    reset      = 1'b1;
    uart_write = 1'b0;
    uart_data  = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(uart_busy), 32'd0);
    check("rst_idle", 32'(tx_idle), 32'd1);
    rx_en = 1'b1;
    tick();

    // Single byte 0x55: latency, bit order, frame length, return to idle
    build_table(8'h55, 8'h00, 1, 44);
    run_table("t1");
    drain("t1");

    // Six consecutive writes: fifth fills the FIFO, sixth is dropped
    rxq.delete();
    n0 = cyc;
    for (int i = 0; i < 6; i++) begin
      uart_write = 1'b1;
      uart_data  = 8'h41 + 8'(i);
      if (i == 1) check("t2_pop_n1", 32'(tx_idle), 32'd0);
      if (i == 4) check("t2_busy_n4", 32'(uart_busy), 32'd0);
      if (i == 5) check("t2_busy_n5", 32'(uart_busy), 32'd1);
      tick();
    end
    uart_write = 1'b0;
    drain("t2");
    check("t2_nframes", 32'(rxq.size()), 32'd5);
    if (rxq.size() == 5) begin
      check("t2_first_start", 32'(rxq[0].start), 32'(n0 + 2));
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t2_byte%0d", i), 32'(rxq[i].b), 32'(8'h41 + 8'(i)));
        check($sformatf("t2_stop%0d", i), 32'(rxq[i].stop_ok), 32'd1);
        if (i > 0)
          check($sformatf("t2_gap%0d", i), 32'(rxq[i].start - rxq[i-1].start), 32'(Frame));
      end
    end

    // Hold uart_write high with a full FIFO: the write coinciding with the
    // end-of-frame pop is dropped, the next one is accepted
    rxq.delete();
    for (int i = 0; i < 44; i++) begin
      uart_write = 1'b1;
      uart_data  = 8'hA0 + 8'(i);
      if (i == 41) check("t3_busy_pop", 32'(uart_busy), 32'd1);
      if (i == 42) check("t3_busy_fall", 32'(uart_busy), 32'd0);
      if (i == 43) check("t3_busy_rise", 32'(uart_busy), 32'd1);
      tick();
    end
    uart_write = 1'b0;
    drain("t3");
    check("t3_nframes", 32'(rxq.size()), 32'd6);
    if (rxq.size() == 6) begin
      for (int i = 0; i < 5; i++) begin
        check($sformatf("t3_byte%0d", i), 32'(rxq[i].b), 32'(8'hA0 + 8'(i)));
        if (i > 0)
          check($sformatf("t3_gap%0d", i), 32'(rxq[i].start - rxq[i-1].start), 32'(Frame));
      end
      check("t6_drop_on_pop", 32'(rxq[5].b), 32'hCA);
      check("t3_gap5", 32'(rxq[5].start - rxq[4].start), 32'(Frame));
    end

    // 0xFF then 0x00 back-to-back: stop bit exactly one bit time, no gap
    rxq.delete();
    build_table(8'hFF, 8'h00, 2, 86);
    run_table("t4");
    drain("t4");
    check("t4_nframes", 32'(rxq.size()), 32'd2);
    if (rxq.size() == 2) begin
      check("t4_byte0", 32'(rxq[0].b), 32'hFF);
      check("t4_byte1", 32'(rxq[1].b), 32'h00);
    end

    // Reset during data bit 3 with two bytes still queued
    rx_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      uart_write = (i < 3);
      uart_data  = (i == 0) ? 8'h35 : ((i == 1) ? 8'hA5 : 8'h96);
      if (i == 19) begin
        check("t5_bit3", 32'(tx), 32'd0);
        check("t5_queued_busy", 32'(uart_busy), 32'd0);
        reset = 1'b1;
      end
      tick();
    end
    uart_write = 1'b0;
    reset      = 1'b0;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_busy", 32'(uart_busy), 32'd0);
    check("t5_idle", 32'(tx_idle), 32'd1);
    all_quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1 || tx_idle !== 1'b1) all_quiet = 1'b0;
    end
    check("t5_quiet", 32'(all_quiet), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter sitting directly downstream of the memory-map decoder.
- Consumes the decoder's data-register write strobe and the low byte of the CPU store data.
- Buffers bytes in a small FIFO and serialises them 8N1 on the tx pin.
- Returns the busy flag, which the decoder uses to gate writes and exposes as the status register bit 0.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 2.
FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of 2, >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
uart_write  input  1  one-cycle write strobe from the decoder (already gated by !uart_busy).
uart_data  input  8  byte to transmit, bits [7:0] of the CPU store data.
uart_busy  output  1  high when the FIFO is full.
tx  output  1  serial line, idle high; registered.
tx_idle  output  1  high when the FSM is in IDLE and the FIFO is empty.

Behaviour:
- Reset values: tx=1, uart_busy=0, tx_idle=1, FIFO empty (read ptr = write ptr = count = 0), FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame: the frame is aborted and FIFO contents are discarded; tx is 1 on the cycle after reset is sampled.
- FIFO push:
  - A write is accepted when uart_write=1 and count < FIFO_DEPTH, evaluated on the current-cycle count.
  - A write while full is silently dropped, even if a pop happens in the same cycle.
  - Write pointer wraps modulo FIFO_DEPTH.
- FIFO pop:
  - Performed by the FSM only; read pointer wraps modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
- uart_busy = (count == FIFO_DEPTH), driven combinationally from the registered count.
- No same-cycle bypass: a byte written in cycle N is visible to the FSM in cycle N+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If FIFO is non-empty: pop the head into an 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = shift[0] (LSB first); each bit is held CLKS_PER_BIT cycles.
    - At the end of each bit, shift right and increment the bit index.
    - After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle:
    - FIFO non-empty: pop the next byte and go directly to START (frames are back-to-back with no gap).
    - Otherwise go to IDLE.
- tx is registered: state/bit changes decided in cycle K appear on tx in cycle K+1.
- Latency: write in cycle N to an empty, idle block gives pop in N+1 and tx low from N+2 for CLKS_PER_BIT cycles.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Baud counter width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- uart_data is sampled only on an accepted write; later changes do not affect stored bytes.

Test Plan:
1. CLKS_PER_BIT=4. Reset, then write 0x55 at cycle N:
   - tx=1 through N+1.
   - tx=0 for N+2..N+5.
   - Then 1,0,1,0,1,0,1,0, each bit 4 cycles.
   - Stop bit high 4 cycles.
   - tx_idle=1 from cycle N+42 onward.
2. Writes of 0x41..0x46 on consecutive cycles N..N+5:
   - 0x41 pops at N+1.
   - uart_busy=1 at N+5 (count=4); 0x46 is dropped.
   - Receiver model decodes 0x41,0x42,0x43,0x44,0x45 in 200 contiguous cycles with no gaps; no 0x46 is ever sent.
3. With the FIFO full, hold uart_write=1:
   - uart_busy falls in the cycle after the pop at the end of the frame-1 stop bit.
   - The next write is accepted and uart_busy rises again.
4. Write 0xFF then 0x00:
   - Stop bit of frame 1 lasts exactly 4 cycles.
   - tx falls for start of frame 2 on the very next cycle.
   - Frame 2 data bits are all 0.
5. Assert reset for 1 cycle during data bit 3 of a frame with 2 bytes queued:
   - Next cycle: tx=1, uart_busy=0, tx_idle=1.
   - No further frames appear for 100 cycles.
6. Write while full at the same cycle the FSM pops:
   - Count drops by 1 and the written byte is absent from the output stream.
